led_sequencer: RTL and testbench

- Parametrised successor to the fixed counter-plus-impulse LED pair. Integrates the step-rate prescaler and the LED pattern engine in one block.
- Adds selectable patterns: count up, count down, chaser and bounce. Also adds a manual single-step input.
- Sits in the top level between the PLL-derived internal clock and the board LED bank.

---
 rtl/led_sequencer.sv | 119 +++++++++++
 tb/tb_led_sequencer.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// LED pattern sequencer: step-rate prescaler plus count/chaser/bounce pattern engine.
// Optional PWM brightness control is enabled by defining LED_BRIGHTNESS_EN.
module led_sequencer #(
   parameter int N_LEDS   = 16,
   parameter int TICK_DIV = 50_000_000,
   parameter int PWM_W    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [1:0]        mode,
   input  logic              step_req,
`ifdef LED_BRIGHTNESS_EN
   input  logic [PWM_W-1:0]  brightness,
`endif
   output logic              tick,
   output logic [N_LEDS-1:0] led
);

   localparam int              PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      M_COUNT_UP   = 2'b00,
      M_COUNT_DOWN = 2'b01,
      M_CHASER     = 2'b10,
      M_BOUNCE     = 2'b11
   } mode_t;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_t;

   generate
      if (N_LEDS < 2 || N_LEDS > 32 || TICK_DIV < 1 || PWM_W < 1) begin : g_bad_param
         $error("led_sequencer: illegal parameter value");
      end
   endgenerate

   logic [PS_W-1:0]   r_presc;
   logic [N_LEDS-1:0] r_pat;
   dir_t              r_dir;
   logic              r_tick;

   mode_t             w_mode;
   logic              w_auto;
   logic              w_step;
   logic              w_onehot;
   logic [N_LEDS-1:0] w_pat_next;
   dir_t              w_dir_next;

   assign w_mode   = mode_t'(mode);
   assign w_auto   = en && (r_presc == PS_LAST);
   // Manual steps bypass en; coincident auto and manual requests merge into one step.
   assign w_step   = w_auto || step_req;
   assign w_onehot = (r_pat != '0) && ((r_pat & (r_pat - N_LEDS'(1))) == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc <= '0;
         r_pat   <= '0;
         r_dir   <= DIR_LEFT;
         r_tick  <= 1'b0;
      end else begin
         if (en) begin
            r_presc <= (r_presc == PS_LAST) ? '0 : r_presc + PS_W'(1);
         end
         r_tick <= w_step;
         if (w_step) begin
            r_pat <= w_pat_next;
            r_dir <= w_dir_next;
         end
      end
   end

   always_comb begin
      w_pat_next = r_pat;
      w_dir_next = r_dir;
      case (w_mode)
         M_COUNT_UP:   w_pat_next = r_pat + N_LEDS'(1);
         M_COUNT_DOWN: w_pat_next = r_pat - N_LEDS'(1);
         M_CHASER: begin
            if (w_onehot) w_pat_next = {r_pat[N_LEDS-2:0], r_pat[N_LEDS-1]};
            else          w_pat_next = N_LEDS'(1);
         end
         M_BOUNCE: begin
            // Direction flips on the step that reaches an end, so each end LED shows for one step.
            if (!w_onehot) begin
               w_pat_next = N_LEDS'(1);
               w_dir_next = DIR_LEFT;
            end else if (r_dir == DIR_LEFT) begin
               w_pat_next = r_pat << 1;
               if (w_pat_next[N_LEDS-1]) w_dir_next = DIR_RIGHT;
            end else begin
               w_pat_next = r_pat >> 1;
               if (w_pat_next == N_LEDS'(1)) w_dir_next = DIR_LEFT;
            end
         end
         default: ;
      endcase
   end

   assign tick = r_tick;

`ifdef LED_BRIGHTNESS_EN
   logic [PWM_W-1:0] r_pwm;

   always_ff @(posedge clk) begin
      if (rst) r_pwm <= '0;
      else     r_pwm <= r_pwm + PWM_W'(1);
   end

   assign led = r_pat & {N_LEDS{r_pwm < brightness}};
`else
   assign led = r_pat;
`endif

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer (N_LEDS=8, TICK_DIV=4): directed scenario tasks plus a
// reference model that queues expected LED values on every step and checks them on tick.
module tb_led_sequencer;

   localparam int N  = 8;
   localparam int TD = 4;
   localparam int PW = 4;

   logic         clk      = 1'b0;
   logic         rst      = 1'b1;
   logic         en       = 1'b0;
   logic [1:0]   mode     = 2'b00;
   logic         step_req = 1'b0;
`ifdef LED_BRIGHTNESS_EN
   logic [PW-1:0] brightness = 4'd15;
`endif
   logic         tick;
   logic [N-1:0] led;

   int n_checks = 0;
   int n_errors = 0;

   logic [N-1:0] exp_q[$];
   logic [N-1:0] exp_v;

   int           m_presc = 0;
   logic [N-1:0] m_pat   = '0;
   logic         m_dir   = 1'b0;
   logic [PW-1:0] m_pwm  = '0;
   logic [N:0]   m_nxt;
   logic [N-1:0] vis_mask;

   logic [N-1:0] bounce_seq [0:14] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                       8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

   led_sequencer #(.N_LEDS(N), .TICK_DIV(TD), .PWM_W(PW)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .mode       (mode),
      .step_req   (step_req),
`ifdef LED_BRIGHTNESS_EN
      .brightness (brightness),
`endif
      .tick       (tick),
      .led        (led)
   );

   always #5 clk = ~clk;

`ifdef LED_BRIGHTNESS_EN
   assign vis_mask = (m_pwm < brightness) ? '1 : '0;
`else
   assign vis_mask = '1;
`endif

   function automatic logic [N:0] model_next(input logic [N-1:0] p, input logic d,
                                             input logic [1:0] m);
      logic [N-1:0] q;
      logic         nd;
      q  = p;
      nd = d;
      case (m)
         2'b00: q = p + 1'b1;
         2'b01: q = p - 1'b1;
         2'b10: q = ($countones(p) == 1) ? {p[N-2:0], p[N-1]} : N'(1);
         default: begin
            if ($countones(p) != 1) begin
               q  = N'(1);
               nd = 1'b0;
            end else if (!d) begin
               q = p << 1;
               if (q[N-1]) nd = 1'b1;
            end else begin
               q = p >> 1;
               if (q == N'(1)) nd = 1'b0;
            end
         end
      endcase
      return {nd, q};
   endfunction

   assign m_nxt = model_next(m_pat, m_dir, mode);

   // Reference model: inputs are stable at the rising edge (driven 1 time unit after it).
   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            m_presc = 0;
            m_pat   = '0;
            m_dir   = 1'b0;
            m_pwm   = '0;
            exp_q.delete();
         end else begin
            if ((en && m_presc == TD - 1) || step_req) begin
               exp_q.push_back(m_nxt[N-1:0]);
               m_dir = m_nxt[N];
               m_pat = m_nxt[N-1:0];
            end
            if (en) m_presc = (m_presc == TD - 1) ? 0 : m_presc + 1;
            m_pwm = m_pwm + 1'b1;
         end
      end
   end

   // Scoreboard: pop an expected value on every tick; a pending value without tick is an error.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (tick) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_errors++;
                  $display("FAIL sb_unexpected_tick: tick=1 with no pending step, led=%h", led);
               end else begin
                  exp_v = exp_q.pop_front();
                  if (led !== (exp_v & vis_mask)) begin
                     n_errors++;
                     $display("FAIL sb_step_led: led=%h expected %h", led, exp_v & vis_mask);
                  end
               end
            end else if (exp_q.size() != 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL sb_missing_tick: tick=0 with %0d pending step(s)", exp_q.size());
               exp_q.delete();
            end
            n_checks++;
            if (led !== (m_pat & vis_mask)) begin
               n_errors++;
               $display("FAIL sb_led_hold: led=%h expected %h", led, m_pat & vis_mask);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_step(input logic [1:0] m);
      mode     = m;
      step_req = 1'b1;
      cyc();
      step_req = 1'b0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_reset_autostep();
      logic exp_tick;
      en   = 1'b1;
      mode = 2'b00;
      rst  = 1'b1;
      cyc();
      cyc();
      n_checks++;
      if (led !== 8'h00) begin
         n_errors++;
         $display("FAIL reset_led: led=%h expected 00", led);
      end
      n_checks++;
      if (tick !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_tick: tick=%b expected 0", tick);
      end
      rst = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         cyc();
         exp_tick = (k % 4 == 0);
         n_checks++;
         if (tick !== exp_tick) begin
            n_errors++;
            $display("FAIL autostep_tick: cycle %0d tick=%b expected %b", k, tick, exp_tick);
         end
         if (exp_tick) begin
            n_checks++;
            if (led !== (N'(k / 4) & vis_mask)) begin
               n_errors++;
               $display("FAIL autostep_led: cycle %0d led=%h expected %h", k, led, N'(k / 4) & vis_mask);
            end
         end
      end
   endtask

   task automatic test_en_freeze();
      cyc();
      cyc();
      en = 1'b0;
      for (int k = 0; k < 10; k++) begin
         cyc();
         n_checks++;
         if (tick !== 1'b0 || led !== (8'h03 & vis_mask)) begin
            n_errors++;
            $display("FAIL freeze: tick=%b led=%h expected tick 0 led %h", tick, led, 8'h03 & vis_mask);
         end
      end
      en = 1'b1;
      cyc();
      n_checks++;
      if (tick !== 1'b0) begin
         n_errors++;
         $display("FAIL resume_early: tick=%b expected 0", tick);
      end
      cyc();
      n_checks++;
      if (tick !== 1'b1 || led !== (8'h04 & vis_mask)) begin
         n_errors++;
         $display("FAIL resume_step: tick=%b led=%h expected tick 1 led %h", tick, led, 8'h04 & vis_mask);
      end
      en       = 1'b0;
      step_req = 1'b1;
      cyc();
      step_req = 1'b0;
      n_checks++;
      if (tick !== 1'b1 || led !== (8'h05 & vis_mask)) begin
         n_errors++;
         $display("FAIL manual_while_disabled: tick=%b led=%h expected tick 1 led %h", tick, led, 8'h05 & vis_mask);
      end
      cyc();
      n_checks++;
      if (tick !== 1'b0) begin
         n_errors++;
         $display("FAIL manual_single_tick: tick=%b expected 0", tick);
      end
   endtask

   task automatic test_simultaneous();
      en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         n_checks++;
         if (tick !== 1'b0) begin
            n_errors++;
            $display("FAIL simul_pre: cycle %0d tick=%b expected 0", k, tick);
         end
      end
      step_req = 1'b1;
      cyc();
      step_req = 1'b0;
      en       = 1'b0;
      n_checks++;
      if (tick !== 1'b1 || led !== (8'h06 & vis_mask)) begin
         n_errors++;
         $display("FAIL simul_step: tick=%b led=%h expected tick 1 led %h", tick, led, 8'h06 & vis_mask);
      end
      cyc();
      n_checks++;
      if (tick !== 1'b0 || led !== (8'h06 & vis_mask)) begin
         n_errors++;
         $display("FAIL simul_single: tick=%b led=%h expected tick 0 led %h", tick, led, 8'h06 & vis_mask);
      end
   endtask

   task automatic test_wrap();
      en = 1'b0;
      apply_reset();
      do_step(2'b01);
      n_checks++;
      if (tick !== 1'b1 || led !== (8'hFF & vis_mask)) begin
         n_errors++;
         $display("FAIL wrap_down: tick=%b led=%h expected tick 1 led %h", tick, led, 8'hFF & vis_mask);
      end
      cyc();
      n_checks++;
      if (tick !== 1'b0) begin
         n_errors++;
         $display("FAIL wrap_down_once: tick=%b expected 0", tick);
      end
      do_step(2'b00);
      n_checks++;
      if (tick !== 1'b1 || led !== 8'h00) begin
         n_errors++;
         $display("FAIL wrap_up: tick=%b led=%h expected tick 1 led 00", tick, led);
      end
      cyc();
      n_checks++;
      if (tick !== 1'b0) begin
         n_errors++;
         $display("FAIL wrap_up_once: tick=%b expected 0", tick);
      end
   endtask

   task automatic test_bounce();
      logic [N-1:0] e;
      en = 1'b0;
      apply_reset();
      for (int k = 0; k < 6; k++) do_step(2'b00);
      do_step(2'b11);
      n_checks++;
      if (led !== (8'h01 & vis_mask)) begin
         n_errors++;
         $display("FAIL bounce_load: led=%h expected %h", led, 8'h01 & vis_mask);
      end
      for (int i = 0; i < 15; i++) begin
         do_step(2'b11);
         e = bounce_seq[i];
         n_checks++;
         if (led !== (e & vis_mask)) begin
            n_errors++;
            $display("FAIL bounce_seq: step %0d led=%h expected %h", i, led, e & vis_mask);
         end
      end
      for (int i = 0; i < 6; i++) do_step(2'b11);
      n_checks++;
      if (led !== (8'h80 & vis_mask)) begin
         n_errors++;
         $display("FAIL bounce_top: led=%h expected %h", led, 8'h80 & vis_mask);
      end
      do_step(2'b10);
      n_checks++;
      if (led !== (8'h01 & vis_mask)) begin
         n_errors++;
         $display("FAIL chaser_wrap: led=%h expected %h", led, 8'h01 & vis_mask);
      end
      rst      = 1'b1;
      step_req = 1'b1;
      cyc();
      rst      = 1'b0;
      step_req = 1'b0;
      n_checks++;
      if (led !== 8'h00 || tick !== 1'b0) begin
         n_errors++;
         $display("FAIL midreset: led=%h tick=%b expected led 00 tick 0", led, tick);
      end
      cyc();
      n_checks++;
      if (led !== 8'h00 || tick !== 1'b0) begin
         n_errors++;
         $display("FAIL midreset_discard: led=%h tick=%b expected led 00 tick 0", led, tick);
      end
      do_step(2'b10);
      n_checks++;
      if (led !== (8'h01 & vis_mask)) begin
         n_errors++;
         $display("FAIL chaser_load: led=%h expected %h", led, 8'h01 & vis_mask);
      end
      do_step(2'b11);
      n_checks++;
      if (led !== (8'h02 & vis_mask)) begin
         n_errors++;
         $display("FAIL dir_after_reset: led=%h expected %h", led, 8'h02 & vis_mask);
      end
   endtask

`ifdef LED_BRIGHTNESS_EN
   task automatic test_brightness();
      int on_cnt;
      en = 1'b0;
      apply_reset();
      do_step(2'b01);
      brightness = 4'd0;
      for (int k = 0; k < 16; k++) begin
         cyc();
         n_checks++;
         if (led !== 8'h00) begin
            n_errors++;
            $display("FAIL bright0: led=%h expected 00", led);
         end
      end
      brightness = 4'd4;
      on_cnt = 0;
      for (int k = 0; k < 16; k++) begin
         cyc();
         if (led === 8'hFF) on_cnt++;
      end
      n_checks++;
      if (on_cnt != 4) begin
         n_errors++;
         $display("FAIL bright4_duty: on cycles=%0d expected 4", on_cnt);
      end
      brightness = 4'd15;
      on_cnt = 0;
      for (int k = 0; k < 16; k++) begin
         cyc();
         if (led === 8'hFF) on_cnt++;
      end
      n_checks++;
      if (on_cnt != 15) begin
         n_errors++;
         $display("FAIL bright15_duty: on cycles=%0d expected 15", on_cnt);
      end
   endtask
`endif

   initial begin
      test_reset_autostep();
      test_en_freeze();
      test_simultaneous();
      test_wrap();
      test_bounce();
`ifdef LED_BRIGHTNESS_EN
      test_brightness();
`endif
      cyc();
      cyc();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
